rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and the long-latency multiply/divide unit (MDU). MDU results are buffered in a small pending queue and drained in idle writeback slots. A bounded-wait guard stalls the pipeline for one cycle if an MDU result starves. Pending-destination lookups let decode detect RAW hazards against buffered MDU writes.

---
 rtl/rf_write_arbiter_pkg.sv | 13 +
 rtl/rf_write_arbiter_if.sv | 32 +++
 rtl/rf_wb_pend_queue.sv | 57 +++++
 rtl/rf_write_arbiter.sv | 84 ++++++++
 tb/tb_rf_write_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared types and defaults for the register-file write arbiter
package rf_write_arbiter_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_MAX_WAIT = 8;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 5;
  typedef struct packed {
    logic                  valid;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] data;
  } pend_entry_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_Q, GNT_SKIP} gnt_src_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback, MDU, decode-lookup and register-file write signals
interface rf_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
);
  logic              wb_wen;
  logic [ADDR_W-1:0] wb_regsrc;
  logic [DATA_W-1:0] wb_regwdata;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_waddr;
  logic [DATA_W-1:0] mdu_wdata;
  logic              pipe_stall;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic              rd_pend0;
  logic              rd_pend1;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  pend_count;
  modport master (
    output wb_wen, wb_regsrc, wb_regwdata, mdu_valid, mdu_waddr, mdu_wdata, rd_addr0, rd_addr1,
    input  mdu_ready, pipe_stall, rd_pend0, rd_pend1, rf_wen, rf_waddr, rf_wdata, pend_count
  );
  modport slave (
    input  wb_wen, wb_regsrc, wb_regwdata, mdu_valid, mdu_waddr, mdu_wdata, rd_addr0, rd_addr1,
    output mdu_ready, pipe_stall, rd_pend0, rd_pend1, rf_wen, rf_waddr, rf_wdata, pend_count
  );
endinterface

// File: rtl/rf_wb_pend_queue.sv
// rf_wb_pend_queue: circular buffer of pending MDU writes with kill-by-address and lookup
module rf_wb_pend_queue
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  pend_entry_t           i_push_entry,
  input  logic                  i_pop,
  input  logic                  i_kill,
  input  logic [PKG_ADDR_W-1:0] i_kill_addr,
  input  logic [PKG_ADDR_W-1:0] i_rd_addr0,
  input  logic [PKG_ADDR_W-1:0] i_rd_addr1,
  output pend_entry_t           o_head,
  output logic [CW-1:0]         o_count,
  output logic                  o_hit0,
  output logic                  o_hit1
);
  pend_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  // Freed slots drop valid so the lookup can scan every slot without occupancy masks.
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i].valid <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill && r_mem[i].addr == i_kill_addr) r_mem[i].valid <= 1'b0;
      if (i_pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  always_comb begin
    o_hit0 = 1'b0;
    o_hit1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit0 = o_hit0 | (r_mem[i].valid && r_mem[i].addr == i_rd_addr0);
      o_hit1 = o_hit1 | (r_mem[i].valid && r_mem[i].addr == i_rd_addr1);
    end
  end
  assign o_head = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the RF write port between writeback and buffered MDU results
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int DATA_W = PKG_DATA_W,
  parameter int ADDR_W = PKG_ADDR_W,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int WW = $clog2(MAX_WAIT + 1)
) (
  input logic               clk,
  input logic               reset,
  rf_write_arbiter_if.slave bus
);
  pend_entry_t       w_head;
  pend_entry_t       w_push_entry;
  gnt_src_e          w_gnt;
  gnt_src_e          w_head_gnt;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_wb_req;
  logic              w_hit0;
  logic              w_hit1;
  logic [WW-1:0]     r_wait;
  logic              r_rf_wen;
  logic              r_from_q;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  assign w_empty = w_count == '0;
  assign bus.mdu_ready = w_count < CW'(DEPTH);
  assign bus.pipe_stall = !w_empty && r_wait == WW'(MAX_WAIT);
  assign w_wb_req = bus.wb_wen && bus.wb_regsrc != '0;
  assign w_push = bus.mdu_valid && bus.mdu_ready && bus.mdu_waddr != '0;
  assign w_push_entry = '{valid: 1'b1, addr: bus.mdu_waddr, data: bus.mdu_wdata};
  always_comb begin
    w_head_gnt = w_head.valid ? GNT_Q : GNT_SKIP;
    w_gnt = bus.pipe_stall ? w_head_gnt : w_wb_req ? GNT_WB : !w_empty ? w_head_gnt : GNT_NONE;
  end
  assign w_pop = w_gnt == GNT_Q || w_gnt == GNT_SKIP;
  rf_wb_pend_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill       (w_gnt == GNT_WB),
    .i_kill_addr  (bus.wb_regsrc),
    .i_rd_addr0   (bus.rd_addr0),
    .i_rd_addr1   (bus.rd_addr1),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_hit0       (w_hit0),
    .o_hit1       (w_hit1)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_wait     <= '0;
      r_rf_wen   <= 1'b0;
      r_from_q   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_wait   <= (w_empty || w_pop) ? '0 : (r_wait == WW'(MAX_WAIT)) ? r_wait : r_wait + 1'b1;
      r_rf_wen <= w_gnt == GNT_WB || w_gnt == GNT_Q;
      r_from_q <= w_gnt == GNT_Q;
      if (w_gnt == GNT_WB) begin
        r_rf_waddr <= bus.wb_regsrc;
        r_rf_wdata <= bus.wb_regwdata;
      end else if (w_gnt == GNT_Q) begin
        r_rf_waddr <= w_head.addr;
        r_rf_wdata <= w_head.data;
      end
    end
  // A queue-sourced write in flight is still pending until the RF actually holds it.
  assign bus.rd_pend0 = bus.rd_addr0 != '0 && (w_hit0 || (r_from_q && r_rf_waddr == bus.rd_addr0));
  assign bus.rd_pend1 = bus.rd_addr1 != '0 && (w_hit1 || (r_from_q && r_rf_waddr == bus.rd_addr1));
  assign bus.rf_wen = r_rf_wen;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;
  assign bus.pend_count = w_count;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table plus scoreboarded sequences for rf_write_arbiter
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  rf_write_arbiter_if #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) bus ();
  rf_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic wen; logic [4:0] src; logic [31:0] data; logic exp_wen; } vec_t;
  wr_t  sb[$];
  vec_t vt[5];
  wr_t  got;
  int n_run = 0;
  int n_fail = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(logic en, logic [4:0] a, logic [31:0] d);
    bus.wb_wen = en;
    bus.wb_regsrc = a;
    bus.wb_regwdata = d;
  endtask
  task automatic mdu(logic v, logic [4:0] a, logic [31:0] d);
    bus.mdu_valid = v;
    bus.mdu_waddr = a;
    bus.mdu_wdata = d;
  endtask
  task automatic idle();
    wb(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
  endtask
  task automatic exp_wr(logic [4:0] a, logic [31:0] d);
    sb.push_back('{a, d});
  endtask
  always @(negedge clk)
    if (bus.rf_wen === 1'b1) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write", bus.rf_waddr, bus.rf_wdata);
      end else begin
        got = sb.pop_front();
        chk("sb_addr", bus.rf_waddr, got.addr);
        chk("sb_data", bus.rf_wdata, got.data);
      end
    end
  initial begin
    int k;
    vt[0] = '{1'b1, 5'd5, 32'h1234, 1'b1};
    vt[1] = '{1'b1, 5'd0, 32'hDEAD, 1'b0};
    vt[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
    vt[3] = '{1'b0, 5'd6, 32'h1, 1'b0};
    vt[4] = '{1'b1, 5'd1, 32'h0, 1'b1};
    idle();
    bus.rd_addr0 = 5'd0;
    bus.rd_addr1 = 5'd0;
    step();
    step();
    chk("rst_wen", bus.rf_wen, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_cnt", bus.pend_count, 0);
    chk("rst_ready", bus.mdu_ready, 1);
    chk("rst_stall", bus.pipe_stall, 0);
    reset = 1'b0;
    foreach (vt[i]) begin
      wb(vt[i].wen, vt[i].src, vt[i].data);
      if (vt[i].exp_wen) exp_wr(vt[i].src, vt[i].data);
      step();
      chk("t1_wen", bus.rf_wen, vt[i].exp_wen);
    end
    idle();
    step();
    bus.rd_addr0 = 5'd7;
    mdu(1'b1, 5'd7, 32'hAA);
    exp_wr(5'd7, 32'hAA);
    step();
    idle();
    chk("t2_cnt1", bus.pend_count, 1);
    chk("t2_pend_q", bus.rd_pend0, 1);
    step();
    chk("t2_wen", bus.rf_wen, 1);
    chk("t2_pend_out", bus.rd_pend0, 1);
    chk("t2_cnt0", bus.pend_count, 0);
    step();
    chk("t2_pend_clr", bus.rd_pend0, 0);
    chk("t2_wen_off", bus.rf_wen, 0);
    mdu(1'b1, 5'd0, 32'hBB);
    step();
    idle();
    chk("t2_zero_cnt", bus.pend_count, 0);
    step();
    chk("t2_zero_wen", bus.rf_wen, 0);
    k = 0;
    for (int c = 0; c < 13; c++) begin
      wb(1'b1, 5'd1, 32'h100 + k);
      if (c == 0) mdu(1'b1, 5'd9, 32'h99);
      else mdu(1'b0, 5'd0, 32'd0);
      chk("t3_stall", bus.pipe_stall, c == 9);
      if (c == 9) exp_wr(5'd9, 32'h99);
      else begin
        exp_wr(5'd1, 32'h100 + k);
        k++;
      end
      step();
    end
    idle();
    step();
    step();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      wb(1'b1, 5'd2, 32'h200 + k);
      if (c < 4) mdu(1'b1, 5'(10 + c), 32'hA0 + c);
      else mdu(c <= 10, 5'd14, 32'hA4);
      chk("t4_ready", bus.mdu_ready, c < 4 || c == 10);
      chk("t4_stall", bus.pipe_stall, c == 9);
      if (c == 4 || c == 11) chk("t4_full", bus.pend_count, 4);
      if (c == 9) exp_wr(5'd10, 32'hA0);
      else begin
        exp_wr(5'd2, 32'h200 + k);
        k++;
      end
      step();
    end
    idle();
    for (int i = 1; i < 5; i++) exp_wr(5'(10 + i), 32'hA0 + i);
    repeat (5) step();
    chk("t4_drained", bus.pend_count, 0);
    bus.rd_addr1 = 5'd3;
    wb(1'b1, 5'd4, 32'h44);
    exp_wr(5'd4, 32'h44);
    mdu(1'b1, 5'd3, 32'h55);
    step();
    chk("t5_pend_before", bus.rd_pend1, 1);
    wb(1'b1, 5'd3, 32'h66);
    exp_wr(5'd3, 32'h66);
    mdu(1'b0, 5'd0, 32'd0);
    step();
    idle();
    chk("t5_pend_killed", bus.rd_pend1, 0);
    chk("t5_cnt_skip", bus.pend_count, 1);
    step();
    chk("t5_skip_wen", bus.rf_wen, 0);
    chk("t5_cnt0", bus.pend_count, 0);
    wb(1'b1, 5'd4, 32'h45);
    exp_wr(5'd4, 32'h45);
    mdu(1'b1, 5'd3, 32'h55);
    step();
    wb(1'b1, 5'd3, 32'h66);
    exp_wr(5'd3, 32'h66);
    mdu(1'b1, 5'd3, 32'h77);
    step();
    idle();
    chk("t5_new_kept", bus.rd_pend1, 1);
    chk("t5_cnt2", bus.pend_count, 2);
    exp_wr(5'd3, 32'h77);
    step();
    step();
    step();
    chk("t5b_cnt0", bus.pend_count, 0);
    for (int c = 0; c < 3; c++) begin
      wb(1'b1, 5'd2, 32'h300 + c);
      exp_wr(5'd2, 32'h300 + c);
      mdu(1'b1, 5'(20 + c), 32'h500 + c);
      step();
    end
    idle();
    chk("t6_cnt3", bus.pend_count, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_wen", bus.rf_wen, 0);
    chk("t6_cnt", bus.pend_count, 0);
    chk("t6_ready", bus.mdu_ready, 1);
    chk("t6_stall", bus.pipe_stall, 0);
    repeat (12) step();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
